div_by_3_serial: RTL

DIV_BY_3_SERIAL -- requirements
Module: div_by_3_serial

---
 rtl/div_by_3_serial.sv | 95 +++++++++
 1 files changed

// File: rtl/div_by_3_serial.sv
// Serial mod-3 checker: scans the operand MSB first, one bit per cycle; result DATA_W cycles after accept.
// Result holds until out_ready; in_ready is low while busy or while an unconsumed result is pending.
module div_by_3_serial #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_div,
   output logic [1:0]        out_rem
);
   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state;
   logic [DATA_W-1:0] shreg;
   logic [CNT_W-1:0]  cnt;
   logic [1:0]        rem;
   logic [1:0]        rem_next;
   logic              accept;

   assign in_ready = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
   assign accept   = in_valid && in_ready;

   // rem_next = (2*rem + bit) mod 3, enumerated so the register can never reach 3
   always_comb begin
      rem_next = 2'd0;
      case ({rem, shreg[DATA_W-1]})
         3'b000:  rem_next = 2'd0;
         3'b001:  rem_next = 2'd1;
         3'b010:  rem_next = 2'd2;
         3'b011:  rem_next = 2'd0;
         3'b100:  rem_next = 2'd1;
         3'b101:  rem_next = 2'd2;
         default: rem_next = 2'd0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         shreg     <= '0;
         cnt       <= '0;
         rem       <= 2'd0;
         out_valid <= 1'b0;
         out_div   <= 1'b0;
         out_rem   <= 2'd0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  shreg <= in_data;
                  rem   <= 2'd0;
                  cnt   <= CNT_LOAD;
                  state <= BUSY;
               end
            end
            BUSY: begin
               shreg <= {shreg[DATA_W-2:0], 1'b0};
               cnt   <= cnt - CNT_ONE;
               rem   <= rem_next;
               if (cnt == CNT_ONE) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  out_rem   <= rem_next;
                  out_div   <= (rem_next == 2'd0);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  out_div   <= 1'b0;
                  // consume and reload in the same edge keeps throughput at DATA_W+1
                  if (accept) begin
                     shreg <= in_data;
                     rem   <= 2'd0;
                     cnt   <= CNT_LOAD;
                     state <= BUSY;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
